symbol_sequencer: RTL and testbench
===================================

# symbol_sequencer

Feeds the 3-dimensional symbol modulator with one 5-bit symbol every SAMPLES_PER_SYMBOL clocks. Buffers upstream encoder symbols in a small FIFO and frames them with a fixed preamble. Holds each symbol stable for exactly one symbol period, phase-aligned to the modulator's internal sample counter. It sits between the encoder/feed logic and the modulator, on the modulator's sample clock.

## Interface
- SYMBOL_WIDTH, 5: symbol bits; split as x0 = sym[4:3], x1 = sym[2:1], x2 = sym[0]
- SAMPLES_PER_SYMBOL, 10: clocks per symbol; must match the modulator
- COUNTER_SIZE, 4: sample counter width, ≥ clog2(SAMPLES_PER_SYMBOL+1)
- FIFO_DEPTH, 4: buffered symbols; power of two
- PREAMBLE_LEN, 8: preamble symbols per frame, ≥ 1
- PREAMBLE_SYMBOL, 5'h15: symbol sent during the preamble
- IDLE_SYMBOL, 5'h00: symbol sent when no frame is active
- clk  in  1  sample clock, shared with the modulator
- rst  in  1  synchronous, active-high reset; must be the same reset as the modulator
- enable  in  1  allows frames to start and continue
- in_valid  in  1  upstream symbol valid
- in_symbol  in  SYMBOL_WIDTH  upstream symbol
- in_ready  out  1  FIFO can accept a symbol
- x0  out  2  modulator dimension 0 input
- x1  out  2  modulator dimension 1 input
- x2  out  1  modulator dimension 2 input
- sym_start  out  1  high during the first sample cycle of each symbol
- state  out  2  current FSM state
- frame_end  out  1  one-cycle pulse on every DATA→IDLE transition
- underrun  out  1  one-cycle pulse when a frame ends because the FIFO was empty

## Operation
- **Sample counter** (sample_cnt)
  - Reset value 1; increments each clock; wraps SAMPLES_PER_SYMBOL→1.
  - Identical to the modulator's counter, so both stay aligned because they share rst.
  - boundary = (sample_cnt == SAMPLES_PER_SYMBOL).
  - sym_start = (sample_cnt == 1), decoded combinationally; it is high in the first cycle after reset.
- **Symbol register** (sym_reg) drives x0/x1/x2 directly. It loads only on a boundary edge.
- **FIFO**
  - in_ready = !full, decoded combinationally from the entry count.
  - Push when in_valid && in_ready.
  - Pop only on a boundary edge in DATA.
  - Empty/full tests use the count before the edge. A push arriving in the same cycle is not bypassed to a pop.
  - Push and pop in the same cycle leave the count unchanged.
- **FSM** (state changes occur only on boundary edges):
  - IDLE (0): loads IDLE_SYMBOL. If enable && FIFO non-empty, go to PREAMBLE, load PREAMBLE_SYMBOL, pre_cnt=1.
  - PREAMBLE (1):
    - If !enable: go to IDLE, load IDLE_SYMBOL; frame_end is not pulsed.
    - Else if pre_cnt == PREAMBLE_LEN: go to DATA, pop the FIFO, load its head. The FIFO is guaranteed non-empty because nothing pops during PREAMBLE.
    - Else: pre_cnt++, reload PREAMBLE_SYMBOL.
  - DATA (2):
    - If !enable: go to IDLE, load IDLE_SYMBOL, pulse frame_end. The FIFO keeps its entries.
    - Else if FIFO empty: go to IDLE, load IDLE_SYMBOL, pulse frame_end and underrun.
    - Else: pop, load head, stay in DATA.
- Encoding 3 is unreachable; if entered, recover to IDLE on the next boundary.

## Timing
- Reset values:
  - x0 = 0, x1 = 0, x2 = 0 (IDLE_SYMBOL)
  - state = IDLE, sample_cnt = 1, FIFO empty, in_ready = 1
  - frame_end = 0, underrun = 0, pre_cnt = 0
- Reset mid-operation takes effect on the same edge. Any frame in progress is dropped and FIFO contents are discarded.
- Outputs are registered, except in_ready and sym_start.
- The symbol is held for exactly SAMPLES_PER_SYMBOL clocks. The value changes on the same edge where the modulator counter wraps to 1.
- frame_end and underrun are high for the single cycle after the boundary edge, i.e. coincident with sym_start.
- Start latency:
  - From the first push into an empty FIFO in IDLE with enable=1, PREAMBLE starts at the next boundary edge: 1 to SAMPLES_PER_SYMBOL clocks.
  - The first data symbol appears PREAMBLE_LEN*SAMPLES_PER_SYMBOL clocks after PREAMBLE starts.
- Upstream throughput: at most 1 symbol per SAMPLES_PER_SYMBOL clocks is drained. Upstream must respect in_ready.

## Structure
- Shared include/package `modem_defs`:
  - state encodings ST_IDLE=0, ST_PREAMBLE=1, ST_DATA=2
  - the PREAMBLE_SYMBOL and IDLE_SYMBOL defaults
  - the symbol field split positions (shared with the modulator wrapper)
- Sub-module `symbol_fifo`: synchronous FIFO parameterised by width/depth, with push/pop/full/empty/count. Everything else lives in symbol_sequencer.

## Test plan
All scenarios use defaults: SAMPLES_PER_SYMBOL=10, PREAMBLE_LEN=8, FIFO_DEPTH=4.
- Reset release → x0/x1/x2 = 0, state=0, in_ready=1; sym_start high in cycles 1, 11, 21, …
- enable=1, push 5'h1F, 5'h0A, 5'h11 → sequence is:
  - 8 symbols of 5'h15 (x0=2'b10, x1=2'b10, x2=1)
  - then 1F, 0A, 11, each held exactly 10 clocks
  - then 5'h00 with frame_end and underrun pulsed once.
- enable=0, offer 5 symbols back-to-back → 4 accepted; in_ready low after the 4th push; 5th held by upstream; x outputs stay 0.
- Drop enable during the 2nd data symbol (4 queued) → that symbol completes all 10 clocks, then 5'h00; frame_end=1, underrun=0; FIFO count=2.
- In DATA with FIFO empty, push 5'h07 in the boundary cycle → frame ends with underrun. The next frame starts one symbol later with 8 preamble symbols, then 5'h07.
- Assert rst at sample 5 of a data symbol → next cycle: outputs 0, state=0, FIFO empty, sample_cnt=1. Alignment with the modulator is preserved.

Source files
------------

// File: rtl/modem_defs.sv
// Shared modem definitions: sequencer state encodings, default framing symbols
// and the symbol field split used by both the sequencer and the modulator wrapper.
package modem_defs;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } seq_state_e;

    localparam int SYM_W = 5;

    localparam logic [4:0] PREAMBLE_SYMBOL_DEF = 5'h15;
    localparam logic [4:0] IDLE_SYMBOL_DEF     = 5'h00;

    localparam int X0_MSB = 4;
    localparam int X0_LSB = 3;
    localparam int X1_MSB = 2;
    localparam int X1_LSB = 1;
    localparam int X2_BIT = 0;

endpackage

// File: rtl/symbol_fifo.sv
// Small synchronous FIFO with a show-ahead head word; pushes into a full FIFO
// and pops from an empty FIFO are ignored.
module symbol_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are invalidated by the pointer reset alone.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= din;
    end

endmodule

// File: rtl/symbol_sequencer.sv
// Frames buffered encoder symbols with a preamble and presents one symbol per
// modulator symbol period, phase-aligned to the modulator's sample counter.
module symbol_sequencer
    import modem_defs::*;
#(
    parameter int                    SYMBOL_WIDTH       = SYM_W,
    parameter int                    SAMPLES_PER_SYMBOL = 10,
    parameter int                    COUNTER_SIZE       = 4,
    parameter int                    FIFO_DEPTH         = 4,
    parameter int                    PREAMBLE_LEN       = 8,
    parameter logic [SYMBOL_WIDTH-1:0] PREAMBLE_SYMBOL  = PREAMBLE_SYMBOL_DEF,
    parameter logic [SYMBOL_WIDTH-1:0] IDLE_SYMBOL      = IDLE_SYMBOL_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    in_valid,
    input  logic [SYMBOL_WIDTH-1:0] in_symbol,
    output logic                    in_ready,
    output logic [1:0]              x0,
    output logic [1:0]              x1,
    output logic                    x2,
    output logic                    sym_start,
    output logic [1:0]              state,
    output logic                    frame_end,
    output logic                    underrun
);

    localparam int PCW = $clog2(PREAMBLE_LEN + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [COUNTER_SIZE-1:0] SPS_C     = COUNTER_SIZE'(SAMPLES_PER_SYMBOL);
    localparam logic [COUNTER_SIZE-1:0] CNT_ONE_C = COUNTER_SIZE'(1);
    localparam logic [PCW-1:0]          PRE_LEN_C = PCW'(PREAMBLE_LEN);
    localparam logic [PCW-1:0]          PRE_ONE_C = PCW'(1);

    logic [COUNTER_SIZE-1:0] sample_cnt_r;
    logic                    boundary_s;
    seq_state_e              state_r;
    seq_state_e              next_state_s;
    logic [SYMBOL_WIDTH-1:0] sym_r;
    logic [SYMBOL_WIDTH-1:0] sym_next_s;
    logic [PCW-1:0]          pre_cnt_r;
    logic [PCW-1:0]          pre_cnt_next_s;
    logic                    pop_s;
    logic                    frame_end_s;
    logic                    underrun_s;
    logic                    frame_end_r;
    logic                    underrun_r;
    logic [SYMBOL_WIDTH-1:0] fifo_head_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [FCW-1:0]          fifo_count_s;

    assign boundary_s = (sample_cnt_r == SPS_C);
    assign sym_start  = (sample_cnt_r == CNT_ONE_C);
    assign in_ready   = !fifo_full_s;
    assign x0         = sym_r[X0_MSB:X0_LSB];
    assign x1         = sym_r[X1_MSB:X1_LSB];
    assign x2         = sym_r[X2_BIT];
    assign state      = state_r;
    assign frame_end  = frame_end_r;
    assign underrun   = underrun_r;

    symbol_fifo #(
        .WIDTH (SYMBOL_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && !fifo_full_s),
        .pop   (boundary_s && pop_s),
        .din   (in_symbol),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Sample counter, identical to the modulator's so both wrap on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_r <= CNT_ONE_C;
        end else if (boundary_s) begin
            sample_cnt_r <= CNT_ONE_C;
        end else begin
            sample_cnt_r <= sample_cnt_r + CNT_ONE_C;
        end
    end

    // Next-state, next-symbol and pulse decode; only committed on a boundary edge.
    always_comb begin
        next_state_s   = state_r;
        sym_next_s     = sym_r;
        pre_cnt_next_s = pre_cnt_r;
        pop_s          = 1'b0;
        frame_end_s    = 1'b0;
        underrun_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && (fifo_count_s != '0)) begin
                    next_state_s   = ST_PREAMBLE;
                    sym_next_s     = PREAMBLE_SYMBOL;
                    pre_cnt_next_s = PRE_ONE_C;
                end else begin
                    next_state_s   = ST_IDLE;
                    sym_next_s     = IDLE_SYMBOL;
                end
            end
            ST_PREAMBLE: begin
                if (!enable) begin
                    next_state_s   = ST_IDLE;
                    sym_next_s     = IDLE_SYMBOL;
                end else if (pre_cnt_r == PRE_LEN_C) begin
                    next_state_s   = ST_DATA;
                    sym_next_s     = fifo_head_s;
                    pop_s          = 1'b1;
                end else begin
                    pre_cnt_next_s = pre_cnt_r + PRE_ONE_C;
                    sym_next_s     = PREAMBLE_SYMBOL;
                end
            end
            ST_DATA: begin
                if (!enable) begin
                    next_state_s   = ST_IDLE;
                    sym_next_s     = IDLE_SYMBOL;
                    frame_end_s    = 1'b1;
                end else if (fifo_empty_s) begin
                    next_state_s   = ST_IDLE;
                    sym_next_s     = IDLE_SYMBOL;
                    frame_end_s    = 1'b1;
                    underrun_s     = 1'b1;
                end else begin
                    sym_next_s     = fifo_head_s;
                    pop_s          = 1'b1;
                end
            end
            default: begin
                next_state_s   = ST_IDLE;
                sym_next_s     = IDLE_SYMBOL;
            end
        endcase
    end

    // Registered state, held symbol and end-of-frame pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            sym_r       <= IDLE_SYMBOL;
            pre_cnt_r   <= '0;
            frame_end_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            if (boundary_s) begin
                state_r   <= next_state_s;
                sym_r     <= sym_next_s;
                pre_cnt_r <= pre_cnt_next_s;
            end
            frame_end_r <= boundary_s && frame_end_s;
            underrun_r  <= boundary_s && underrun_s;
        end
    end

endmodule

// File: tb/tb_symbol_sequencer.sv
// Directed bench for symbol_sequencer: framing, back-pressure, enable drop,
// underrun restart and mid-frame reset, with hand-computed expectations.
module tb_symbol_sequencer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       in_valid;
    logic [4:0] in_symbol;
    logic       in_ready;
    logic [1:0] x0;
    logic [1:0] x1;
    logic       x2;
    logic       sym_start;
    logic [1:0] state;
    logic       frame_end;
    logic       underrun;

    int checks;
    int failures;
    int ph;

    symbol_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_symbol (in_symbol),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .sym_start (sym_start),
        .state     (state),
        .frame_end (frame_end),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ph tracks the expected sample counter value in the current cycle
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) ph = 1;
        else     ph = (ph == 10) ? 1 : ph + 1;
    endtask

    task automatic wait_ph(input int p);
        int n;
        n = 0;
        tick();
        while (ph != p && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic hold_symbol(input string tag, input logic [4:0] sym, input logic [1:0] st,
                               input int periods, input logic fe, input logic ur,
                               input int drop_at, input int push_at, input logic [4:0] push_sym);
        for (int p = 0; p < periods; p++) begin
            for (int c = 0; c < 10; c++) begin
                check_value({tag, "_sym"},   32'({x0, x1, x2}), 32'(sym));
                check_value({tag, "_state"}, 32'(state), 32'(st));
                check_value({tag, "_fe"},    32'(frame_end), 32'((p == 0 && c == 0) ? fe : 1'b0));
                check_value({tag, "_ur"},    32'(underrun),  32'((p == 0 && c == 0) ? ur : 1'b0));
                check_value({tag, "_start"}, 32'(sym_start), 32'(c == 0));
                if (c == drop_at) enable = 1'b0;
                if (c == push_at) begin
                    in_valid  = 1'b1;
                    in_symbol = push_sym;
                end
                tick();
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        ph        = 1;
        rst       = 1'b1;
        enable    = 1'b0;
        in_valid  = 1'b0;
        in_symbol = 5'h00;
        repeat (3) tick();
        rst = 1'b0;

        // reset state and sym_start cadence
        check_value("rst_x",       32'({x0, x1, x2}), 32'h0);
        check_value("rst_state",   32'(state), 32'h0);
        check_value("rst_ready",   32'(in_ready), 32'h1);
        check_value("rst_fe",      32'(frame_end), 32'h0);
        check_value("rst_ur",      32'(underrun), 32'h0);
        check_value("rst_cnt",     32'(dut.sample_cnt_r), 32'h1);
        check_value("rst_pre_cnt", 32'(dut.pre_cnt_r), 32'h0);
        for (int i = 0; i < 20; i++) begin
            check_value("cadence_start", 32'(sym_start), 32'(ph == 1));
            tick();
        end

        // basic frame: three symbols then underrun
        enable    = 1'b1;
        in_valid  = 1'b1;
        in_symbol = 5'h1F; tick();
        in_symbol = 5'h0A; tick();
        in_symbol = 5'h11; tick();
        in_valid  = 1'b0;
        wait_ph(1);
        hold_symbol("b_pre",  5'h15, 2'd1, 8, 1'b0, 1'b0, -1, -1, 5'h00);
        hold_symbol("b_d0",   5'h1F, 2'd2, 1, 1'b0, 1'b0, -1, -1, 5'h00);
        hold_symbol("b_d1",   5'h0A, 2'd2, 1, 1'b0, 1'b0, -1, -1, 5'h00);
        hold_symbol("b_d2",   5'h11, 2'd2, 1, 1'b0, 1'b0, -1, -1, 5'h00);
        hold_symbol("b_idle", 5'h00, 2'd0, 1, 1'b1, 1'b1, -1, -1, 5'h00);

        // back-pressure with enable low
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid  = 1'b1;
            in_symbol = 5'(k + 1);
            check_value("bp_ready", 32'(in_ready), 32'(k < 4));
            check_value("bp_x",     32'({x0, x1, x2}), 32'h0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            check_value("bp_hold_ready", 32'(in_ready), 32'h0);
            check_value("bp_hold_x",     32'({x0, x1, x2}), 32'h0);
            tick();
        end
        in_valid = 1'b0;
        check_value("bp_count", 32'(dut.u_fifo.count), 32'h4);

        // enable drop during the second data symbol
        wait_ph(1);
        enable = 1'b1;
        wait_ph(1);
        hold_symbol("d_pre",  5'h15, 2'd1, 8, 1'b0, 1'b0, -1, -1, 5'h00);
        hold_symbol("d_d0",   5'h01, 2'd2, 1, 1'b0, 1'b0, -1, -1, 5'h00);
        hold_symbol("d_d1",   5'h02, 2'd2, 1, 1'b0, 1'b0,  5, -1, 5'h00);
        hold_symbol("d_idle", 5'h00, 2'd0, 1, 1'b1, 1'b0, -1, -1, 5'h00);
        check_value("d_count", 32'(dut.u_fifo.count), 32'h2);

        // drain, then push in the boundary cycle of an empty-FIFO data symbol
        enable = 1'b1;
        hold_symbol("e_wait",  5'h00, 2'd0, 1, 1'b0, 1'b0, -1, -1, 5'h00);
        hold_symbol("e_pre",   5'h15, 2'd1, 8, 1'b0, 1'b0, -1, -1, 5'h00);
        hold_symbol("e_d0",    5'h03, 2'd2, 1, 1'b0, 1'b0, -1, -1, 5'h00);
        hold_symbol("e_d1",    5'h04, 2'd2, 1, 1'b0, 1'b0, -1,  9, 5'h07);
        hold_symbol("e_idle",  5'h00, 2'd0, 1, 1'b1, 1'b1, -1, -1, 5'h00);
        hold_symbol("e_pre2",  5'h15, 2'd1, 8, 1'b0, 1'b0, -1, -1, 5'h00);
        hold_symbol("e_d2",    5'h07, 2'd2, 1, 1'b0, 1'b0, -1, -1, 5'h00);
        hold_symbol("e_idle2", 5'h00, 2'd0, 1, 1'b1, 1'b1, -1, -1, 5'h00);

        // reset at sample 5 of a data symbol
        in_valid  = 1'b1;
        in_symbol = 5'h1A; tick();
        in_symbol = 5'h05; tick();
        in_valid  = 1'b0;
        wait_ph(1);
        hold_symbol("f_pre", 5'h15, 2'd1, 8, 1'b0, 1'b0, -1, -1, 5'h00);
        for (int c = 0; c < 5; c++) begin
            check_value("f_sym", 32'({x0, x1, x2}), 32'h1A);
            if (c < 4) tick();
        end
        rst = 1'b1;
        tick();
        check_value("f_rst_x",     32'({x0, x1, x2}), 32'h0);
        check_value("f_rst_state", 32'(state), 32'h0);
        check_value("f_rst_count", 32'(dut.u_fifo.count), 32'h0);
        check_value("f_rst_cnt",   32'(dut.sample_cnt_r), 32'h1);
        check_value("f_rst_ready", 32'(in_ready), 32'h1);
        check_value("f_rst_start", 32'(sym_start), 32'h1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check_value("f_cadence", 32'(sym_start), 32'(ph == 1));
            check_value("f_idle_x",  32'({x0, x1, x2}), 32'h0);
            check_value("f_idle_st", 32'(state), 32'h0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
